// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the mips core memory path.
//   dmem_state_t          - data-memory controller FSM states
//   DMEM_TIMEOUT_DEFAULT  - default abort limit for a memory access (cycles)
//   DMEM_ERR_*            - error cause codes, reserved for a status register
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } dmem_state_t;

   localparam int DMEM_TIMEOUT_DEFAULT = 255;

   localparam logic [1:0] DMEM_ERR_NONE     = 2'd0;
   localparam logic [1:0] DMEM_ERR_MISALIGN = 2'd1;
   localparam logic [1:0] DMEM_ERR_CONFLICT = 2'd2;
   localparam logic [1:0] DMEM_ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt: cycle counter bounding how long one memory access may take.
//   clock   in  - system clock, rising edge
//   reset   in  - asynchronous active-low reset
//   clear   in  - restart counting from zero (access starts)
//   enable  in  - count this cycle (access in flight)
//   expired out - this is the TIMEOUT-th counted cycle; the access must abort
module dmem_timeout_cnt
   import mips_pkg::*;
#(
   parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   // Count holds k during the (k+1)-th in-flight cycle, so the limit is hit
   // one below TIMEOUT; the controller leaves REQ/RESP on that edge.
   assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the mips memory stage and
// a variable-latency memory port.
//   clock, reset                 - clock (rising edge), async active-low reset
//   cpu_mem_read/cpu_mem_write   - core MemRead / MemWrite
//   cpu_addr, cpu_wdata          - core byte address and store data
//   cpu_rdata                    - registered load data
//   cpu_stall                    - freeze core while an access is in flight
//   cpu_err                      - one-cycle pulse: misaligned, conflict, timeout
//   mem_req_*                    - request channel toward memory
//   mem_resp_valid/rdata         - read response from memory
//   dbg_state                    - current FSM state (dmem_state_t encoding)
//
// Handshake: a request transfers on a rising edge where mem_req_valid and
// mem_req_ready are both 1. mem_req_valid is registered and never depends on
// mem_req_ready; once raised, valid/we/addr/wdata hold until the transfer or a
// timeout abort. mem_resp_valid is sampled only in RESP, one beat per read.
module dmem_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_mem_read,
   input  logic              cpu_mem_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_rdata,
   output logic [1:0]        dbg_state
);

   dmem_state_t state;

   logic any_access;
   logic aligned;
   logic valid_access;
   logic bad_access;
   logic cnt_clear;
   logic cnt_enable;
   logic expired;

   assign any_access   = cpu_mem_read | cpu_mem_write;
   assign aligned      = (cpu_addr[1:0] == 2'b00);
   assign valid_access = (cpu_mem_read ^ cpu_mem_write) & aligned;
   assign bad_access   = (cpu_mem_read & cpu_mem_write) | (any_access & ~aligned);

   assign cnt_clear  = (state == IDLE) && valid_access;
   assign cnt_enable = (state == REQ) || (state == RESP);

   dmem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear   (cnt_clear),
      .enable  (cnt_enable),
      .expired (expired)
   );

   // Stall must rise in the same cycle the core presents the access, so it is
   // combinational; gated by reset so every output reads 0 while in reset.
   assign cpu_stall = reset & (((state == IDLE) & valid_access) |
                               (state == REQ) | (state == RESP));

   assign dbg_state = state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cpu_rdata     <= '0;
         cpu_err       <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
      end else begin
         cpu_err <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_access) begin
                  state         <= REQ;
                  mem_req_valid <= 1'b1;
                  mem_req_we    <= cpu_mem_write;
                  mem_req_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  mem_req_wdata <= cpu_wdata;
               end else if (bad_access) begin
                  cpu_err <= 1'b1;
               end
            end
            REQ: begin
               // A transfer on the expiring cycle still completes normally.
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= mem_req_we ? DONE : RESP;
               end else if (expired) begin
                  mem_req_valid <= 1'b0;
                  cpu_rdata     <= '0;
                  cpu_err       <= 1'b1;
                  state         <= DONE;
               end
            end
            RESP: begin
               if (mem_resp_valid) begin
                  cpu_rdata <= mem_resp_rdata;
                  state     <= DONE;
               end else if (expired) begin
                  cpu_rdata <= '0;
                  cpu_err   <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // Core advances on this edge, so the access is never reissued.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl (TIMEOUT overridden to 8).
module tb_dmem_ctrl;
   import mips_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   // ---------------- clock / reset ----------------
   logic          clock = 1'b0;
   logic          reset;
   logic          cpu_mem_read;
   logic          cpu_mem_write;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   logic          cpu_err;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_we;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_wdata;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_rdata;
   logic [1:0]    dbg_state;

   always #5 clock = ~clock;

   dmem_ctrl #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cpu_mem_read   (cpu_mem_read),
      .cpu_mem_write  (cpu_mem_write),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_rdata      (cpu_rdata),
      .cpu_stall      (cpu_stall),
      .cpu_err        (cpu_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .dbg_state      (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int            n_checks = 0;
   int            n_pass   = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_rdata = '0;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_mem_read   = 1'b0;
      cpu_mem_write  = 1'b0;
      cpu_addr       = '0;
      cpu_wdata      = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if ({cpu_rdata, cpu_stall, cpu_err, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata} !== '0)
         $display("FAIL reset_outputs: rdata=%h stall=%b err=%b valid=%b we=%b addr=%h wdata=%h, all must be 0",
                  cpu_rdata, cpu_stall, cpu_err, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
      else n_pass++;
      n_checks++;
      if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
      else n_pass++;
      step();
      reset = 1'b1;
   endtask

   // One complete aligned access with a memory model that raises ready after
   // rdy_dly REQ cycles and resp_valid after rsp_dly RESP cycles.
   task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] rdata, input int rdy_dly, input int rsp_dly,
                            input string name);
      int            exp_stall;
      int            stall_n;
      int            req_n;
      int            rsp_n;
      bit            hs;
      bit            done;
      logic [DW-1:0] exp;
      exp_stall = we ? rdy_dly + 2 : rdy_dly + rsp_dly + 3;
      stall_n = 0; req_n = 0; rsp_n = 0; hs = 0; done = 0;
      step();
      cpu_mem_read   = ~we;
      cpu_mem_write  = we;
      cpu_addr       = addr;
      cpu_wdata      = wdata;
      mem_req_ready  = (rdy_dly == 0);
      mem_resp_valid = 1'b0;
      mem_resp_rdata = rdata;
      exp_q.push_back(we ? wdata : rdata);
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         @(negedge clock);
         if (!cpu_stall) begin
            done = 1;
         end else begin
            stall_n++;
            if (mem_req_valid) begin
               req_n++;
               n_checks++;
               if (mem_req_addr !== {addr[AW-1:2], 2'b00} || mem_req_we !== we ||
                   (we && mem_req_wdata !== wdata))
                  $display("FAIL %s_req_hold: addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                           name, mem_req_addr, mem_req_we, mem_req_wdata, {addr[AW-1:2], 2'b00}, we, wdata);
               else n_pass++;
               if (mem_req_ready) begin
                  hs = 1;
                  if (we) begin
                     n_checks++;
                     if (exp_q.size() == 0) $display("FAIL %s_sb_empty: queue empty at write handshake", name);
                     else begin
                        exp = exp_q.pop_front();
                        if (mem_req_wdata !== exp)
                           $display("FAIL %s_wdata: got %h want %h", name, mem_req_wdata, exp);
                        else n_pass++;
                     end
                  end
               end
            end else if (hs) begin
               rsp_n++;
            end
            step();
            mem_req_ready  = !hs && (req_n >= rdy_dly);
            mem_resp_valid = hs && !we && (rsp_n >= rsp_dly);
         end
      end
      if (!done) begin
         n_checks++;
         $display("FAIL %s_budget: stall still high after 64 cycles, want release", name);
      end else begin
         n_checks++;
         if (stall_n !== exp_stall) $display("FAIL %s_stall_cycles: got %0d want %0d", name, stall_n, exp_stall);
         else n_pass++;
         n_checks++;
         if (cpu_err !== 1'b0 || dbg_state !== DONE)
            $display("FAIL %s_done: err=%b state=%0d want err=0 state=%0d", name, cpu_err, dbg_state, DONE);
         else n_pass++;
         n_checks++;
         if (!we) begin
            if (exp_q.size() == 0) $display("FAIL %s_sb_empty: queue empty at read completion", name);
            else begin
               exp = exp_q.pop_front();
               if (cpu_rdata !== exp) $display("FAIL %s_rdata: got %h want %h", name, cpu_rdata, exp);
               else n_pass++;
               last_rdata = exp;
            end
         end else begin
            if (cpu_rdata !== last_rdata) $display("FAIL %s_rdata_hold: got %h want %h", name, cpu_rdata, last_rdata);
            else n_pass++;
         end
      end
      step();
      idle_inputs();
   endtask

   task automatic test_bad_access(input logic rd, input logic wr, input logic [AW-1:0] addr, input string name);
      step();
      cpu_mem_read  = rd;
      cpu_mem_write = wr;
      cpu_addr      = addr;
      cpu_wdata     = 32'h5555_AAAA;
      mem_req_ready = 1'b1;
      @(negedge clock);
      n_checks++;
      if (cpu_stall !== 1'b0 || mem_req_valid !== 1'b0 || cpu_err !== 1'b0)
         $display("FAIL %s_issue: stall=%b valid=%b err=%b want 0/0/0", name, cpu_stall, mem_req_valid, cpu_err);
      else n_pass++;
      step();
      idle_inputs();
      @(negedge clock);
      n_checks++;
      if (cpu_err !== 1'b1 || mem_req_valid !== 1'b0 || cpu_stall !== 1'b0)
         $display("FAIL %s_err_pulse: err=%b valid=%b stall=%b want 1/0/0", name, cpu_err, mem_req_valid, cpu_stall);
      else n_pass++;
      step();
      @(negedge clock);
      n_checks++;
      if (cpu_err !== 1'b0 || dbg_state !== IDLE || mem_req_valid !== 1'b0)
         $display("FAIL %s_err_end: err=%b state=%0d valid=%b want 0/%0d/0", name, cpu_err, dbg_state, mem_req_valid, IDLE);
      else n_pass++;
   endtask

   task automatic test_read();
      do_access(1'b0, 32'h0000_0010, '0, 32'hCAFE_BABE, 0, 0, "read");
   endtask

   task automatic test_write_backpressure();
      do_access(1'b1, 32'h0000_0020, 32'h1234_5678, '0, 5, 0, "write_bp");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         do_access(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), "b2b");
      end
   endtask

   task automatic test_timeout();
      int  stall_n;
      bit  done;
      stall_n = 0; done = 0;
      step();
      cpu_mem_read   = 1'b1;
      cpu_addr       = 32'h0000_0030;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clock);
         if (!cpu_stall) done = 1;
         else begin
            stall_n++;
            step();
         end
      end
      n_checks++;
      if (!done) $display("FAIL timeout_budget: stall still high after 40 cycles, want abort");
      else if (stall_n !== TO + 1) $display("FAIL timeout_cycles: got %0d stall cycles want %0d", stall_n, TO + 1);
      else n_pass++;
      n_checks++;
      if (cpu_err !== 1'b1 || cpu_rdata !== '0 || mem_req_valid !== 1'b0)
         $display("FAIL timeout_abort: err=%b rdata=%h valid=%b want 1/0/0", cpu_err, cpu_rdata, mem_req_valid);
      else n_pass++;
      last_rdata = '0;
      step();
      idle_inputs();
      @(negedge clock);
      n_checks++;
      if (cpu_err !== 1'b0 || dbg_state !== IDLE)
         $display("FAIL timeout_recover: err=%b state=%0d want 0/%0d", cpu_err, dbg_state, IDLE);
      else n_pass++;
      do_access(1'b0, 32'h0000_0044, '0, 32'hA5A5_0001, 1, 1, "after_to");
   endtask

   task automatic test_reset_mid();
      step();
      cpu_mem_read  = 1'b1;
      cpu_addr      = 32'h0000_0050;
      cpu_wdata     = 32'h7777_7777;
      mem_req_ready = 1'b1;
      step();
      step();
      mem_req_ready = 1'b0;
      @(negedge clock);
      n_checks++;
      if (dbg_state !== RESP) $display("FAIL rst_mid_setup: state=%0d want %0d", dbg_state, RESP);
      else n_pass++;
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({cpu_rdata, cpu_stall, cpu_err, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata} !== '0 ||
          dbg_state !== IDLE)
         $display("FAIL rst_mid_outputs: rdata=%h stall=%b err=%b valid=%b addr=%h wdata=%h state=%0d want all 0",
                  cpu_rdata, cpu_stall, cpu_err, mem_req_valid, mem_req_addr, mem_req_wdata, dbg_state);
      else n_pass++;
      idle_inputs();
      step();
      reset          = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hDEAD_BEEF;
      @(negedge clock);
      step();
      mem_resp_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if (cpu_rdata !== '0 || dbg_state !== IDLE || cpu_stall !== 1'b0 || cpu_err !== 1'b0)
         $display("FAIL rst_late_resp: rdata=%h state=%0d stall=%b err=%b want 0/%0d/0/0",
                  cpu_rdata, dbg_state, cpu_stall, cpu_err, IDLE);
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_read();
      test_write_backpressure();
      test_bad_access(1'b1, 1'b0, 32'h0000_0013, "misalign");
      test_bad_access(1'b1, 1'b1, 32'h0000_0040, "conflict");
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory access controller for the mips core. It replaces the single-cycle zero-latency d_mem path with a handshake to a variable-latency memory port. It consumes the core's memory-stage outputs (ALU address, rt store data, MemRead/MemWrite) and returns read data plus a stall that freezes PC and register writeback until the access completes. It also detects misaligned and timed-out accesses.

Parameters:
ADDR_W, 32, address width (byte address)
DATA_W, 32, data word width
TIMEOUT, 255, max cycles spent in REQ+RESP before abort (8-bit counter)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_mem_read  in  1  core MemRead
cpu_mem_write  in  1  core MemWrite
cpu_addr  in  ADDR_W  core ALU result (byte address)
cpu_wdata  in  DATA_W  core store data (rt)
cpu_rdata  out  DATA_W  load data to MemtoReg mux, registered
cpu_stall  out  1  freeze PC/RegWrite/MemWrite-side effects in core
cpu_err  out  1  one-cycle pulse: misaligned, read+write conflict, or timeout
mem_req_valid  out  1  request valid toward memory
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_W  latched word address
mem_req_wdata  out  DATA_W  latched store data
mem_resp_valid  in  1  read data valid from memory
mem_resp_rdata  in  DATA_W  read data

Behaviour:
- Reset (reset=0, async): state=IDLE; cpu_rdata=0, cpu_stall=0, cpu_err=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, timeout counter=0. Reset mid-access drops mem_req_valid immediately. A pending mem_resp_valid after reset is ignored.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - If exactly one of read/write is set, cpu_addr[1:0]==0: latch addr/wdata/we, go to REQ. cpu_stall=1 combinationally in this cycle.
  - If addr[1:0]!=0 with an access, or both read and write are set: cpu_err=1 next cycle for one cycle. No memory access, no stall, stay IDLE.
  - No access: stay IDLE, stall=0.
- REQ:
  - mem_req_valid=1. mem_req_we/addr/wdata are held stable until mem_req_ready. Valid does not depend combinationally on ready.
  - On ready: a write goes to DONE (no response expected); a read goes to RESP.
- RESP: wait for mem_resp_valid. On valid, capture mem_resp_rdata into cpu_rdata and go to DONE. mem_resp_valid in any other state is ignored.
- DONE:
  - cpu_stall=0 for exactly one cycle; cpu_rdata is stable.
  - Unconditionally return to IDLE. The core advances on this edge, so the same access is never reissued.
- cpu_stall = (IDLE & valid-access) | REQ | RESP.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or RESP.
  - When it reaches TIMEOUT: mem_req_valid drops, cpu_rdata=0, cpu_err=1 for one cycle, go to DONE.
  - A handshake completing in the same cycle as the timeout wins: normal completion, no error.
- Minimum latency: read costs 3 stall cycles (IDLE, REQ, RESP); write costs 2 stall cycles (IDLE, REQ).
- cpu_rdata holds its last value until the next completed read or a timeout.
- mem_req_addr is forced word-aligned ([1:0]=0).

Decomposition:
- Shared package mips_pkg holds:
  - dmem_state_t enum {IDLE, REQ, RESP, DONE}
  - DMEM_TIMEOUT_DEFAULT = 255
  - DMEM_ERR_* cause constants (MISALIGN, CONFLICT, TIMEOUT), for a future status register
- One sub-module, dmem_timeout_cnt: clear/enable/expired, width from TIMEOUT.
- The FSM and latches stay in dmem_ctrl.

Test Plan:
- Read, ready=1 at REQ, resp_valid next cycle with 0xCAFEBABE at addr 0x10 -> stall high 3 cycles; DONE cycle has cpu_rdata=0xCAFEBABE and stall=0; req addr=0x10, we=0.
- Write 0x12345678 to 0x20, ready held low 5 cycles -> valid/addr/wdata stable all 5 cycles; stall drops the cycle after ready; no err.
- Read at addr 0x13 -> cpu_err pulse 1 cycle, stall never high, mem_req_valid never high.
- Read with resp_valid never asserted, TIMEOUT=8 -> err pulse after 8 REQ+RESP cycles, cpu_rdata=0, back to IDLE, next access proceeds normally.
- reset=0 asserted in RESP -> all outputs 0 immediately; a late resp_valid after release is ignored; state IDLE.
- MemRead=MemWrite=1 at addr 0x40 -> err pulse, no request issued.
